// File: rtl/apb4_cmd_master.sv
// APB4 requester: turns a valid/ready command stream into single APB4 transfers
// and returns read data / error status on a valid/ready response stream.
// A bounded ACCESS-phase wait counter aborts transfers whose PREADY never rises.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready high only in IDLE)
//   cmd_write/addr/wdata/strb/prot  command payload, latched on acceptance
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata/err/timeout     response payload, held until rsp_ready
//   busy                      transfer or response outstanding
//   m_apb_*                   APB4 requester pins
module apb4_cmd_master #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic                    m_apb_psel,
    output logic                    m_apb_penable,
    output logic                    m_apb_pwrite,
    output logic [2:0]              m_apb_pprot,
    output logic [ADDR_WIDTH-1:0]   m_apb_paddr,
    output logic [DATA_WIDTH-1:0]   m_apb_pwdata,
    output logic [DATA_WIDTH/8-1:0] m_apb_pstrb,
    input  logic [DATA_WIDTH-1:0]   m_apb_prdata,
    input  logic                    m_apb_pready,
    input  logic                    m_apb_pslverr
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state, state_d;
    logic [CNT_W-1:0]        wait_cnt, wait_cnt_d;
    logic                    psel_d, penable_d, pwrite_d;
    logic [2:0]              pprot_d;
    logic [ADDR_WIDTH-1:0]   paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_d;
    logic [STRB_W-1:0]       pstrb_d;
    logic                    rsp_valid_d, rsp_err_d, rsp_timeout_d, busy_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d;
    logic                    timeout_hit;

    // Command acceptance is a direct decode of the state register.
    assign cmd_ready = (state == IDLE);

    // wait_cnt holds completed ACCESS cycles, so the current cycle is wait_cnt+1.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         ((32'(wait_cnt) + 32'd1) >= TIMEOUT_CYCLES);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            m_apb_psel    <= 1'b0;
            m_apb_penable <= 1'b0;
            m_apb_pwrite  <= 1'b0;
            m_apb_pprot   <= '0;
            m_apb_paddr   <= '0;
            m_apb_pwdata  <= '0;
            m_apb_pstrb   <= '0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            rsp_timeout   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            wait_cnt      <= wait_cnt_d;
            m_apb_psel    <= psel_d;
            m_apb_penable <= penable_d;
            m_apb_pwrite  <= pwrite_d;
            m_apb_pprot   <= pprot_d;
            m_apb_paddr   <= paddr_d;
            m_apb_pwdata  <= pwdata_d;
            m_apb_pstrb   <= pstrb_d;
            rsp_valid     <= rsp_valid_d;
            rsp_rdata     <= rsp_rdata_d;
            rsp_err       <= rsp_err_d;
            rsp_timeout   <= rsp_timeout_d;
            busy          <= busy_d;
        end
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_d       = state;
        wait_cnt_d    = wait_cnt;
        psel_d        = m_apb_psel;
        penable_d     = m_apb_penable;
        pwrite_d      = m_apb_pwrite;
        pprot_d       = m_apb_pprot;
        paddr_d       = m_apb_paddr;
        pwdata_d      = m_apb_pwdata;
        pstrb_d       = m_apb_pstrb;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;
        busy_d        = busy;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    pprot_d   = cmd_prot;
                    paddr_d   = cmd_addr & ALIGN_MASK;
                    // Reads carry no data and must drive all-zero strobes.
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    pstrb_d   = cmd_write ? cmd_strb  : '0;
                    busy_d    = 1'b1;
                end
            end
            SETUP: begin
                state_d    = ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = '0;
            end
            ACCESS: begin
                // PREADY takes priority over a coincident timeout.
                if (m_apb_pready) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = m_apb_pwrite ? '0 : m_apb_prdata;
                    rsp_err_d     = m_apb_pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Self-checking bench for apb4_cmd_master: directed corner cases plus random
// transfers against a cycle-count reference model and a simple APB slave.
module tb_apb4_cmd_master;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [2:0]    pprot;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic [3:0]    pstrb;

    int n_checks = 0;
    int n_pass   = 0;

    // Slave behaviour: PREADY rises after slv_wait wait-state cycles.
    int unsigned   slv_wait = 0;
    logic          slv_err  = 1'b0;
    logic [DW-1:0] slv_rdata = '0;
    int unsigned   acc_cnt = 0;

    apb4_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_apb_psel(psel), .m_apb_penable(penable), .m_apb_pwrite(pwrite),
        .m_apb_pprot(pprot), .m_apb_paddr(paddr), .m_apb_pwdata(pwdata),
        .m_apb_pstrb(pstrb), .m_apb_prdata(prdata), .m_apb_pready(pready),
        .m_apb_pslverr(pslverr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    assign pready  = psel && penable && (acc_cnt == slv_wait);
    assign prdata  = slv_rdata;
    assign pslverr = slv_err;

    logic [4:0] ctl;
    assign ctl = {cmd_ready, busy, psel, penable, rsp_valid};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // One command through to its response handshake, checked every cycle.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot, input int unsigned wait_n,
                           input logic err, input logic [DW-1:0] rdata, input int unsigned hold);
        bit            timed_out;
        int unsigned   rsp_k;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, e_rdata;
        logic [3:0]    e_strb;
        logic          e_err;

        // Reference model: latency and results from the transfer rules.
        timed_out = (TO != 0) && (wait_n >= TO);
        rsp_k     = 2 + (timed_out ? TO : wait_n + 1);
        e_addr    = addr & 5'h1C;
        e_wdata   = wr ? wdata : '0;
        e_strb    = wr ? strb : 4'h0;
        e_rdata   = (!wr && !timed_out) ? rdata : '0;
        e_err     = timed_out || err;

        @(posedge clk); #1;
        slv_wait = wait_n; slv_err = err; slv_rdata = rdata;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
        @(negedge clk);
        check("idle_ctl", 64'(ctl), 64'(5'b10000));
        @(posedge clk); #1;
        // Keep a different command pending; it must be ignored.
        cmd_write = ~wr; cmd_addr = AW'($urandom); cmd_wdata = $urandom;
        cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
        for (int k = 1; k <= int'(rsp_k); k++) begin
            @(negedge clk);
            check("xfer_ctl", 64'(ctl),
                  64'({1'b0, 1'b1, k < int'(rsp_k), (k >= 2) && (k < int'(rsp_k)), k == int'(rsp_k)}));
            if (k < int'(rsp_k)) begin
                check("apb_payload", 64'({pwrite, pprot, paddr, pwdata, pstrb}),
                      64'({wr, prot, e_addr, e_wdata, e_strb}));
                @(posedge clk);
            end
        end
        check("rsp", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'({e_rdata, e_err, timed_out}));
        for (int h = 0; h < int'(hold); h++) begin
            @(posedge clk); @(negedge clk);
            check("rsp_hold", 64'({ctl, rsp_rdata, rsp_err, rsp_timeout}),
                  64'({5'b01001, e_rdata, e_err, timed_out}));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("post_rsp_ctl", 64'(ctl), 64'(5'b10000));
    endtask

    // Reset while the slave stalls in ACCESS: transfer vanishes without a response.
    task automatic reset_mid_access();
        @(posedge clk); #1;
        slv_wait = 50; slv_err = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h0C;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_ctl", 64'(ctl), 64'(5'b01110));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ctl", 64'(ctl), 64'(5'b10000));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_rsp_after_rst", 64'(ctl), 64'(5'b10000));
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", 64'(ctl), 64'(5'b10000));
        check("rst_outputs", 64'({pwrite, pprot, paddr, pwdata, pstrb, rsp_err, rsp_timeout}), 64'(0));
        check("rst_rdata", 64'(rsp_rdata), 64'(0));
        rst = 1'b0;

        run_txn(1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 32'h0, 0);
        run_txn(1'b0, 5'h08, 32'hAAAA5555, 4'hF, 3'd2, 3, 1'b0, 32'h12345678, 0);
        run_txn(1'b1, 5'h10, 32'h0BADF00D, 4'h3, 3'd1, 0, 1'b1, 32'h0, 2);
        run_txn(1'b0, 5'h14, 32'h0, 4'h0, 3'd0, 100, 1'b0, 32'hCAFEF00D, 0);
        run_txn(1'b0, 5'h18, 32'h0, 4'h0, 3'd0, TO - 1, 1'b0, 32'h55AA55AA, 0);
        run_txn(1'b1, 5'h07, 32'h01020304, 4'h5, 3'd7, 1, 1'b0, 32'h0, 5);

        reset_mid_access();

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), AW'($urandom), $urandom, 4'($urandom), 3'($urandom),
                    $urandom_range(0, 6), 1'($urandom_range(0, 3) == 0), $urandom,
                    $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb4_cmd_master.md
Name: apb4_cmd_master

Overview:
- Synthesizable APB4 requester. It sits directly upstream of the generated regblock and drives its s_apb_* slave port.
- Converts a valid/ready command stream (one read or write per command) into exactly one APB4 transfer. Returns read data and error status on a valid/ready response stream.
- Lets benches and SoC wrappers issue register accesses without hand-timed pin wiggling. Adds a bounded wait-state timeout so a hung PREADY cannot stall the requester.

Parameters:
- DATA_WIDTH, 32: APB data width; only 8/16/32/64 are legal.
- ADDR_WIDTH, 5: APB byte-address width.
- TIMEOUT_CYCLES, 256: maximum ACCESS-phase cycles without PREADY before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- cmd_prot  in  3  PPROT value.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  state != IDLE.
- m_apb_psel, m_apb_penable, m_apb_pwrite  out  1 each  APB4 control.
- m_apb_pprot  out  3  APB4 protection.
- m_apb_paddr  out  ADDR_WIDTH  APB4 address.
- m_apb_pwdata  out  DATA_WIDTH  APB4 write data.
- m_apb_pstrb  out  DATA_WIDTH/8  APB4 strobes.
- m_apb_prdata  in  DATA_WIDTH  APB4 read data.
- m_apb_pready  in  1  APB4 ready.
- m_apb_pslverr  in  1  APB4 slave error.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- Reset: state=IDLE. Every output is 0, including psel, penable, paddr, pwdata, pstrb, pprot, rsp_*, and busy. cmd_ready is 1 combinationally in IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, at edge N: latch the command and enter SETUP.
  - Address is aligned to the word: paddr low log2(DATA_WIDTH/8) bits are forced to 0.
  - pstrb = cmd_strb for writes and 0 for reads (APB4 rule).
  - pwdata = 0 for reads.
- SETUP (cycle N+1): psel=1, penable=0. Unconditionally enter ACCESS.
- ACCESS (from N+2): psel=1, penable=1. paddr, pwrite, pwdata, pstrb, and pprot stay stable for the whole transfer. The wait counter increments each ACCESS cycle.
  - On pready=1: sample prdata (only if read) and pslverr. Drop psel and penable at the same edge and enter RESP.
  - If the counter reaches TIMEOUT_CYCLES with pready still 0: drop psel and penable, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, and enter RESP.
  - If pready and the timeout coincide, pready wins: normal completion, rsp_timeout=0.
- Minimum command-to-response latency is 3 cycles (zero wait states): rsp_valid goes high at N+3.
- RESP:
  - rsp_valid=1. rsp_rdata, rsp_err, and rsp_timeout are held stable until rsp_ready.
  - On rsp_ready, clear rsp_valid and return to IDLE. A new command can be accepted in the first IDLE cycle after that.
  - No command is accepted while a response is pending. At most one transfer is outstanding.
- cmd_ready is 0 in SETUP, ACCESS, and RESP. Changes on cmd_* outside IDLE are ignored.
- Reset mid-transfer: at the next edge, psel and penable drop to 0, rsp_valid drops to 0, and state goes to IDLE. No response is generated for the aborted command.
- The wait counter width is clog2(TIMEOUT_CYCLES+1), minimum 1. It clears on entry to ACCESS.
- busy = 1 from the edge that accepts a command until the response handshake completes.

Test Plan:
- Write, zero wait: cmd write addr 0x04, wdata 0xDEADBEEF, strb 0xF, slave pready=1.
  - psel at N+1, penable at N+2.
  - rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: read addr 0x08, slave holds pready=0 for 3 ACCESS cycles, then returns prdata 0x12345678.
  - rsp_valid at N+6, rsp_rdata=0x12345678.
  - pstrb=0 throughout.
- Slave error: write addr 0x10, slave pready=1 with pslverr=1.
  - rsp_err=1, rsp_timeout=0.
  - Next command is accepted only after rsp_ready.
- Timeout: TIMEOUT_CYCLES=4, pready stuck at 0.
  - psel drops after 4 ACCESS cycles.
  - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - pready=1 on the 4th cycle instead gives normal completion.
- Backpressure and alignment: hold rsp_ready=0 for 5 cycles with a new cmd_valid pending.
  - Response is held stable, cmd_ready stays 0, no APB activity.
  - Unaligned cmd_addr 0x07 drives paddr 0x04.
- Reset mid-ACCESS: assert rst for 1 cycle during wait states.
  - Next edge: psel=penable=0, rsp_valid=0, busy=0, cmd_ready=1.
